// File: rtl/instr_fetch.sv
// instr_fetch: fetches a 16-bit big-endian instruction as two byte reads starting at the latched pc
module instr_fetch #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fetch_start,
   input  logic                  flush,
   input  logic [ADDR_W-1:0]     pc,
   output logic                  mem_rd_en,
   output logic [ADDR_W-1:0]     mem_addr,
   input  logic [DATA_W-1:0]     mem_rdata,
   input  logic                  mem_rvalid,
   output logic [2*DATA_W-1:0]   instr,
   output logic                  fetch_done,
   output logic                  busy
);
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] REQ_HI  = 3'd1;
   localparam logic [2:0] WAIT_HI = 3'd2;
   localparam logic [2:0] REQ_LO  = 3'd3;
   localparam logic [2:0] WAIT_LO = 3'd4;
   localparam logic [2:0] DONE    = 3'd5;
   logic [2:0]        state, nxt;
   logic [ADDR_W-1:0] base;
   logic [DATA_W-1:0] hi_byte;
   logic              start_ok, hi_ok, lo_ok;
   assign start_ok   = state == IDLE && fetch_start && !flush;
   assign hi_ok      = state == WAIT_HI && mem_rvalid && !flush;
   assign lo_ok      = state == WAIT_LO && mem_rvalid && !flush;
   assign mem_rd_en  = state == REQ_HI || state == REQ_LO;
   assign fetch_done = state == DONE;
   assign busy       = state != IDLE;
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = start_ok ? REQ_HI : IDLE;
         REQ_HI:  nxt = WAIT_HI;
         WAIT_HI: nxt = mem_rvalid ? REQ_LO : WAIT_HI;
         REQ_LO:  nxt = WAIT_LO;
         WAIT_LO: nxt = mem_rvalid ? DONE : WAIT_LO;
         default: nxt = IDLE;
      endcase
      if (flush && state != DONE) nxt = IDLE;
   end
   // mem_addr is loaded one cycle ahead of each request so it is registered yet valid in REQ_*
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         base     <= '0;
         hi_byte  <= '0;
         instr    <= '0;
         mem_addr <= '0;
      end else begin
         state <= nxt;
         if (start_ok) begin
            base     <= pc;
            mem_addr <= pc;
         end
         if (hi_ok) begin
            hi_byte  <= mem_rdata;
            mem_addr <= base + ADDR_W'(1);
         end
         if (lo_ok) instr <= {hi_byte, mem_rdata};
      end
   end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized and directed checks of instr_fetch against a transaction-level timing model
module tb_instr_fetch;
   logic        clk = 0;
   logic        rst, fetch_start, flush, mem_rd_en, mem_rvalid, fetch_done, busy;
   logic [2:0]  pc, mem_addr;
   logic [7:0]  mem_rdata;
   logic [15:0] instr;
   logic [7:0]  mem [8];
   logic [15:0] exp_instr;
   logic [2:0]  paddr;
   int          n_chk, n_pass, nreq, cd, lat;
   bit          pend;
   always #5 clk = ~clk;
   instr_fetch dut (
      .clk(clk), .rst(rst), .fetch_start(fetch_start), .flush(flush), .pc(pc),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .mem_rvalid(mem_rvalid), .instr(instr), .fetch_done(fetch_done), .busy(busy)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   // advance one cycle, then play the memory: answer each request lat cycles later
   task automatic tick();
      @(posedge clk);
      #1;
      mem_rvalid = 0;
      mem_rdata  = 8'($urandom);
      if (pend) begin
         cd--;
         if (cd == 0) begin
            mem_rvalid = 1;
            mem_rdata  = mem[paddr];
            pend       = 0;
         end
      end
      if (mem_rd_en) begin
         pend  = 1;
         cd    = lat;
         paddr = mem_addr;
         nreq++;
      end
   endtask
   task automatic drain();
      for (int i = 0; i < 8 && pend; i++) begin
         tick();
         chk("idle_busy", busy, 0);
         chk("idle_done", fetch_done, 0);
         chk("idle_rd_en", mem_rd_en, 0);
      end
   endtask
   // fa: cycle (relative to start) in which flush is held, 0 for none
   task automatic do_fetch(input logic [2:0] p, input int l, input bit repulse, input int fa);
      int lb, n0;
      bit fl;
      logic [2:0] q;
      logic [15:0] nw;
      q  = p + 3'd1;
      nw = {mem[p], mem[q]};
      fl = fa >= 1 && fa < 3 + 2 * l;
      lb = fl ? fa : 3 + 2 * l;
      n0 = nreq;
      lat = l;
      pc = p;
      flush = 0;
      fetch_start = 1;
      for (int r = 1; r <= lb + 1; r++) begin
         tick();
         chk("busy", busy, r <= lb);
         chk("done", fetch_done, !fl && r == lb);
         chk("rd_en", mem_rd_en, r == 1 || (r == 2 + l && r <= lb));
         chk("addr", mem_addr, (r >= 2 + l && 2 + l <= lb) ? q : p);
         if (!fl && r == lb) exp_instr = nw;
         chk("instr", instr, exp_instr);
         pc = 3'($urandom);
         fetch_start = (repulse && r <= lb) ? (r == lb || $urandom_range(0, 1) == 1) : 0;
         flush = (r == fa);
      end
      chk("nreq", nreq - n0, (fl && fa < 2 + l) ? 1 : 2);
      fetch_start = 0;
      flush = 0;
      drain();
   endtask
   initial begin
      logic [2:0] p;
      int l, fa;
      bit rp;
      rst = 1; fetch_start = 0; flush = 0; pc = 0;
      mem_rvalid = 0; mem_rdata = 0; lat = 1; pend = 0;
      n_chk = 0; n_pass = 0; nreq = 0; cd = 0; exp_instr = 0;
      foreach (mem[i]) mem[i] = 8'($urandom);
      repeat (3) tick();
      rst = 0;
      repeat (5) begin
         tick();
         chk("rst_rd_en", mem_rd_en, 0);
         chk("rst_addr", mem_addr, 0);
         chk("rst_instr", instr, 0);
         chk("rst_done", fetch_done, 0);
         chk("rst_busy", busy, 0);
      end
      mem[7] = 8'h12; mem[0] = 8'h34;
      do_fetch(3'd7, 1, 0, 0);
      chk("wrap", instr, 16'h1234);
      do_fetch(3'd5, 3, 1, 0);
      mem[2] = 8'hA5; mem[3] = 8'h3C;
      do_fetch(3'd2, 1, 0, 0);
      chk("basic", instr, 16'hA53C);
      do_fetch(3'd1, 3, 0, 6);
      mem_rvalid = 1;
      mem_rdata  = 8'hFF;
      tick();
      chk("stray_busy", busy, 0);
      chk("flush_keep", instr, 16'hA53C);
      mem[4] = 8'h55; mem[5] = 8'h66;
      do_fetch(3'd4, 1, 0, 0);
      chk("after_flush", instr, 16'h5566);
      lat = 2; pc = 3'd3; fetch_start = 1;
      tick();
      fetch_start = 0;
      tick();
      chk("wait_hi_busy", busy, 1);
      rst = 1;
      tick();
      rst = 0;
      exp_instr = 0;
      chk("mid_rst_rd_en", mem_rd_en, 0);
      chk("mid_rst_addr", mem_addr, 0);
      chk("mid_rst_instr", instr, 0);
      chk("mid_rst_done", fetch_done, 0);
      chk("mid_rst_busy", busy, 0);
      drain();
      tick();
      pc = 3'd6; fetch_start = 1; flush = 1;
      tick();
      fetch_start = 0; flush = 0;
      repeat (3) begin
         chk("coll_rd_en", mem_rd_en, 0);
         chk("coll_busy", busy, 0);
         tick();
      end
      repeat (25) begin
         foreach (mem[i]) mem[i] = 8'($urandom);
         p  = 3'($urandom);
         l  = $urandom_range(1, 4);
         rp = $urandom_range(0, 1) == 1;
         fa = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3 + 2 * l) : 0;
         do_fetch(p, l, rp, fa);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
